riscv_core_int_ctrl: RTL and testbench
======================================

RISCV_CORE_INT_CTRL -- requirements
Module: riscv_core_int_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, CSR data width.
REQ-002 SHALL have parameter NUM_SRC, default 8, external interrupt sources (legal 1..16), IDs 1..NUM_SRC, ID 0 = none.
REQ-003 SHALL have parameter PRIO_W, default 3, per-source priority width; NUM_SRC*PRIO_W <= XLEN.
REQ-004 SHALL have parameter TICK_DIV, default 1, clock cycles per mtime increment (legal >= 1).
REQ-005 i_riscv_core_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_riscv_core_rst  in  1  reset, synchronous, active-high.
REQ-007 i_riscv_core_irq_src  in  NUM_SRC  level-sensitive interrupt sources; bit k-1 is ID k.
REQ-008 i_riscv_core_csr_wen  in  1  register write strobe.
REQ-009 i_riscv_core_csr_waddr  in  12  write address.
REQ-010 i_riscv_core_csr_wdata  in  XLEN  write data.
REQ-011 i_riscv_core_csr_raddr  in  12  read address.
REQ-012 o_riscv_core_csr_rdata  out  XLEN  read data, registered.
REQ-013 i_riscv_core_claim  in  1  one-cycle claim pulse from trap entry.
REQ-014 o_riscv_core_claim_id  out  $clog2(NUM_SRC+1)  claimed ID, registered.
REQ-015 i_riscv_core_complete  in  1  one-cycle completion pulse.
REQ-016 i_riscv_core_complete_id  in  $clog2(NUM_SRC+1)  ID being completed.
REQ-017 o_riscv_core_meip  out  1  machine external interrupt pending, registered.
REQ-018 o_riscv_core_mtip  out  1  machine timer interrupt pending, registered.

Function
REQ-019 Register map: 0x7C0 enable (bits NUM_SRC-1:0), 0x7C1 threshold (PRIO_W bits), 0x7C2 priorities (packed, ID k at bits k*PRIO_W-1:(k-1)*PRIO_W), 0x7C3 pending (read-only), 0x7C5 mtimecmp, 0x7C6 mtime; unmapped reads return 0; unmapped/read-only writes ignored; unused bits read 0.
REQ-020 Read latency: o_riscv_core_csr_rdata SHALL reflect raddr one cycle after it is presented; a same-cycle write is not visible until the following read.
REQ-021 Per-source gateway FSM: IDLE -> PENDING when source high in IDLE; PENDING -> CLAIMED when its ID is claimed; CLAIMED -> IDLE on complete with matching ID; a source falling while PENDING SHALL NOT clear pending.
REQ-022 Arbitration: candidate = PENDING, enabled, priority > threshold; winner = highest priority, ties to lowest ID; no candidate -> winner 0.
REQ-023 o_riscv_core_meip SHALL equal (winner != 0) registered, i.e. one cycle after the candidate set changes.
REQ-024 On claim, o_riscv_core_claim_id SHALL load the winner of the claim cycle next cycle and that source SHALL enter CLAIMED; claim with no winner loads 0 and changes no state; claim_id holds until next claim.
REQ-025 Complete naming an ID not in CLAIMED, or ID 0 / > NUM_SRC, SHALL be ignored.
REQ-026 Claim and complete in the same cycle SHALL both be applied; a completed source still high SHALL become PENDING no earlier than the next cycle.
REQ-027 Lowering priority, threshold or enable SHALL NOT alter PENDING/CLAIMED states, only eligibility.

Reset
REQ-028 During reset: all gateways IDLE, enable/threshold/priorities 0, rdata 0, claim_id 0, meip 0, mtip 0, mtime 0, prescaler 0, mtimecmp all-ones.
REQ-029 Reset asserted mid-claim SHALL discard claimed state; no complete is required afterwards.

Configuration
REQ-030 Macro INT_CTRL_TIMER_EN: defined -> mtime increments by 1 every TICK_DIV cycles, wraps 2^64-1 -> 0, mtip = (mtime >= mtimecmp) registered; a mtime write in a tick cycle wins over the increment and resets the prescaler.
REQ-031 INT_CTRL_TIMER_EN undefined -> no timer storage, 0x7C5/0x7C6 read 0 and ignore writes, o_riscv_core_mtip constant 0.

Verification
REQ-032 Prio 0x7C2: ID1=2, ID3=5, enable=0x05, threshold 1, raise src1 and src3 -> meip=1 one cycle later; claim -> claim_id=3, meip stays 1 (ID1 eligible).
REQ-033 Equal priorities 4 on ID2 and ID5, both high, enabled -> claim returns 2, next claim returns 5, third claim returns 0 and meip=0.
REQ-034 Claim ID4, hold src4 high, complete id=4 -> src4 PENDING one cycle later, meip=1; complete id=6 (never claimed) -> no state change.
REQ-035 Threshold = 5 with only ID1 at priority 5 pending -> meip=0; write threshold 4 -> meip=1 within two cycles of the write.
REQ-036 With INT_CTRL_TIMER_EN, TICK_DIV=1: write mtime=0xFFFF_FFFF_FFFF_FFFE, mtimecmp=0x2 -> mtip=1 then mtime wraps to 0 and mtip=0 until mtime reaches 2; without macro, read 0x7C6 = 0 and mtip=0.
REQ-037 Assert reset with ID2 CLAIMED and mtimecmp=0 -> next cycle claim_id=0, meip=0, mtip=0, read 0x7C5 = 0xFFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/riscv_core_int_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_core_int_ctrl
//
// Purpose:
//   Machine-level interrupt controller for a RISC-V core. It contains one
//   level-sensitive gateway per external source, a priority/threshold
//   arbiter that drives the machine external interrupt line, a claim/complete
//   handshake, and an optional machine timer (mtime/mtimecmp).
//
// Optional feature macro:
//   INT_CTRL_TIMER_EN - when defined, builds the mtime/mtimecmp timer and
//                       drives o_riscv_core_mtip. When undefined, there is no
//                       timer storage, 0x7C5/0x7C6 read as zero and ignore
//                       writes, and o_riscv_core_mtip is tied low.
//
// Ports:
//   i_riscv_core_clk         single clock, rising edge
//   i_riscv_core_rst         synchronous active-high reset
//   i_riscv_core_irq_src     level-sensitive sources, bit k-1 is ID k
//   i_riscv_core_csr_wen     register write strobe
//   i_riscv_core_csr_waddr   write address
//   i_riscv_core_csr_wdata   write data
//   i_riscv_core_csr_raddr   read address
//   o_riscv_core_csr_rdata   registered read data
//   i_riscv_core_claim       one-cycle claim pulse
//   o_riscv_core_claim_id    registered claimed ID (0 = none)
//   i_riscv_core_complete    one-cycle completion pulse
//   i_riscv_core_complete_id ID being completed
//   o_riscv_core_meip        registered external interrupt pending
//   o_riscv_core_mtip        registered timer interrupt pending
//
// Register map:
//   0x7C0 enable, 0x7C1 threshold, 0x7C2 packed priorities,
//   0x7C3 pending (read-only), 0x7C5 mtimecmp, 0x7C6 mtime.
// ---------------------------------------------------------------------------
module riscv_core_int_ctrl #(
  parameter int XLEN     = 64,
  parameter int NUM_SRC  = 8,
  parameter int PRIO_W   = 3,
  parameter int TICK_DIV = 1,
  localparam int IDW     = $clog2(NUM_SRC + 1)
) (
  input  logic               i_riscv_core_clk,
  input  logic               i_riscv_core_rst,
  input  logic [NUM_SRC-1:0] i_riscv_core_irq_src,
  input  logic               i_riscv_core_csr_wen,
  input  logic [11:0]        i_riscv_core_csr_waddr,
  input  logic [XLEN-1:0]    i_riscv_core_csr_wdata,
  input  logic [11:0]        i_riscv_core_csr_raddr,
  output logic [XLEN-1:0]    o_riscv_core_csr_rdata,
  input  logic               i_riscv_core_claim,
  output logic [IDW-1:0]     o_riscv_core_claim_id,
  input  logic               i_riscv_core_complete,
  input  logic [IDW-1:0]     i_riscv_core_complete_id,
  output logic               o_riscv_core_meip,
  output logic               o_riscv_core_mtip
);

  localparam logic [11:0] ADDR_ENABLE   = 12'h7C0;
  localparam logic [11:0] ADDR_THRESH   = 12'h7C1;
  localparam logic [11:0] ADDR_PRIO     = 12'h7C2;
  localparam logic [11:0] ADDR_PENDING  = 12'h7C3;
  localparam logic [11:0] ADDR_MTIMECMP = 12'h7C5;
  localparam logic [11:0] ADDR_MTIME    = 12'h7C6;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gwState_e;

  gwState_e                  gw_q [NUM_SRC];
  gwState_e                  gw_d [NUM_SRC];
  logic [NUM_SRC-1:0]        enable_q, enable_d;
  logic [PRIO_W-1:0]         thresh_q, thresh_d;
  logic [NUM_SRC*PRIO_W-1:0] prio_q, prio_d;
  logic [XLEN-1:0]           rdata_q, rdata_d;
  logic [IDW-1:0]            claimId_q, claimId_d;
  logic                      meip_q, meip_d;

  logic [NUM_SRC-1:0]        pendingVec;
  logic [IDW-1:0]            winner;
  logic [PRIO_W-1:0]         bestPrio;
  logic [PRIO_W-1:0]         srcPrio;

  // Arbiter: the running best starts at the threshold so that only sources
  // strictly above it can win. A strict greater-than comparison while
  // scanning upward from ID 1 makes ties resolve to the lowest ID.
  always_comb begin
    winner   = '0;
    bestPrio = thresh_q;
    srcPrio  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      srcPrio = prio_q[k*PRIO_W +: PRIO_W];
      if (gw_q[k] == GW_PENDING && enable_q[k] && srcPrio > bestPrio) begin
        bestPrio = srcPrio;
        winner   = IDW'(k + 1);
      end
    end
  end

  // Gateway next state. A source that drops while PENDING stays pending;
  // a completed source returns to IDLE and can only re-pend on the
  // following cycle because IDLE samples the level one cycle later.
  // Out-of-range or zero complete IDs simply match no gateway.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      gw_d[k] = gw_q[k];
      case (gw_q[k])
        GW_IDLE: begin
          if (i_riscv_core_irq_src[k]) begin
            gw_d[k] = GW_PENDING;
          end
        end
        GW_PENDING: begin
          if (i_riscv_core_claim && winner == IDW'(k + 1)) begin
            gw_d[k] = GW_CLAIMED;
          end
        end
        GW_CLAIMED: begin
          if (i_riscv_core_complete && i_riscv_core_complete_id == IDW'(k + 1)) begin
            gw_d[k] = GW_IDLE;
          end
        end
        default: gw_d[k] = GW_IDLE;
      endcase
    end
  end

  // Pending register view is just the gateways currently in PENDING.
  always_comb begin
    pendingVec = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pendingVec[k] = (gw_q[k] == GW_PENDING);
    end
  end

  // Writable configuration registers. Only the implemented low bits are
  // kept, so unused bits naturally read back as zero.
  always_comb begin
    enable_d = enable_q;
    thresh_d = thresh_q;
    prio_d   = prio_q;
    if (i_riscv_core_csr_wen) begin
      case (i_riscv_core_csr_waddr)
        ADDR_ENABLE: enable_d = i_riscv_core_csr_wdata[NUM_SRC-1:0];
        ADDR_THRESH: thresh_d = i_riscv_core_csr_wdata[PRIO_W-1:0];
        ADDR_PRIO:   prio_d   = i_riscv_core_csr_wdata[NUM_SRC*PRIO_W-1:0];
        default: ;
      endcase
    end
  end

  // Claim loads whatever wins in the claim cycle, including 0 when nothing
  // is eligible, and then holds until the next claim. meip is the winner
  // flag delayed by one register stage.
  always_comb begin
    claimId_d = claimId_q;
    if (i_riscv_core_claim) begin
      claimId_d = winner;
    end
    meip_d = (winner != '0);
  end

`ifdef INT_CTRL_TIMER_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          mtip_q, mtip_d;
  logic          tick;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Timer: mtime advances once per TICK_DIV cycles and wraps naturally at
  // 64 bits. A software write to mtime overrides the increment in the same
  // cycle and restarts the prescaler so the next tick is a full period away.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    presc_d    = presc_q;
    if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (i_riscv_core_csr_wen && i_riscv_core_csr_waddr == ADDR_MTIME) begin
      mtime_d = 64'(i_riscv_core_csr_wdata);
      presc_d = '0;
    end
    if (i_riscv_core_csr_wen && i_riscv_core_csr_waddr == ADDR_MTIMECMP) begin
      mtimecmp_d = 64'(i_riscv_core_csr_wdata);
    end
    mtip_d = (mtime_q >= mtimecmp_q);
  end

  // Timer state register; mtimecmp resets to all-ones so mtip stays low.
  always_ff @(posedge i_riscv_core_clk) begin
    if (i_riscv_core_rst) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      mtip_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= mtip_d;
    end
  end

  assign o_riscv_core_mtip = mtip_q;
`else
  logic unusedWdata;

  // Without the timer, the upper write-data bits have no destination.
  assign unusedWdata       = ^i_riscv_core_csr_wdata;
  assign o_riscv_core_mtip = 1'b0;
`endif

  // Read mux sampled from current register contents, so a write in the
  // same cycle shows up only on the following read.
  always_comb begin
    rdata_d = '0;
    case (i_riscv_core_csr_raddr)
      ADDR_ENABLE:   rdata_d[NUM_SRC-1:0]        = enable_q;
      ADDR_THRESH:   rdata_d[PRIO_W-1:0]         = thresh_q;
      ADDR_PRIO:     rdata_d[NUM_SRC*PRIO_W-1:0] = prio_q;
      ADDR_PENDING:  rdata_d[NUM_SRC-1:0]        = pendingVec;
`ifdef INT_CTRL_TIMER_EN
      ADDR_MTIMECMP: rdata_d = XLEN'(mtimecmp_q);
      ADDR_MTIME:    rdata_d = XLEN'(mtime_q);
`endif
      default: ;
    endcase
  end

  // Main state register. Reset drops every gateway to IDLE, which also
  // discards any outstanding claim without needing a complete.
  always_ff @(posedge i_riscv_core_clk) begin
    if (i_riscv_core_rst) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        gw_q[k] <= GW_IDLE;
      end
      enable_q  <= '0;
      thresh_q  <= '0;
      prio_q    <= '0;
      rdata_q   <= '0;
      claimId_q <= '0;
      meip_q    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        gw_q[k] <= gw_d[k];
      end
      enable_q  <= enable_d;
      thresh_q  <= thresh_d;
      prio_q    <= prio_d;
      rdata_q   <= rdata_d;
      claimId_q <= claimId_d;
      meip_q    <= meip_d;
    end
  end

  assign o_riscv_core_csr_rdata = rdata_q;
  assign o_riscv_core_claim_id  = claimId_q;
  assign o_riscv_core_meip      = meip_q;

endmodule

// File: tb/tb_riscv_core_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_core_int_ctrl
//
// Directed testbench for riscv_core_int_ctrl with default parameters.
// Timer checks follow INT_CTRL_TIMER_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_riscv_core_int_ctrl;

  localparam int XLEN    = 64;
  localparam int NUM_SRC = 8;
  localparam int IDW     = $clog2(NUM_SRC + 1);

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] irqSrc;
  logic               csrWen;
  logic [11:0]        csrWaddr;
  logic [XLEN-1:0]    csrWdata;
  logic [11:0]        csrRaddr;
  logic [XLEN-1:0]    csrRdata;
  logic               claim;
  logic [IDW-1:0]     claimId;
  logic               complete;
  logic [IDW-1:0]     completeId;
  logic               meip;
  logic               mtip;

  int vectors    = 0;
  int miscompares = 0;

  riscv_core_int_ctrl dut (
    .i_riscv_core_clk         (clk),
    .i_riscv_core_rst         (rst),
    .i_riscv_core_irq_src     (irqSrc),
    .i_riscv_core_csr_wen     (csrWen),
    .i_riscv_core_csr_waddr   (csrWaddr),
    .i_riscv_core_csr_wdata   (csrWdata),
    .i_riscv_core_csr_raddr   (csrRaddr),
    .o_riscv_core_csr_rdata   (csrRdata),
    .i_riscv_core_claim       (claim),
    .o_riscv_core_claim_id    (claimId),
    .i_riscv_core_complete    (complete),
    .i_riscv_core_complete_id (completeId),
    .o_riscv_core_meip        (meip),
    .o_riscv_core_mtip        (mtip)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it, where inputs are
  // driven and registered outputs are sampled.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic csrWrite(input logic [11:0] addr, input logic [63:0] data);
    csrWen   = 1'b1;
    csrWaddr = addr;
    csrWdata = data;
    stepClock();
    csrWen   = 1'b0;
  endtask

  task automatic pulseClaim();
    claim = 1'b1;
    stepClock();
    claim = 1'b0;
  endtask

  task automatic pulseComplete(input logic [IDW-1:0] id);
    complete   = 1'b1;
    completeId = id;
    stepClock();
    complete   = 1'b0;
    completeId = '0;
  endtask

  task automatic applyReset();
    rst    = 1'b1;
    irqSrc = '0;
    claim  = 1'b0;
    complete = 1'b0;
    csrWen = 1'b0;
    stepClock();
    stepClock();
    rst = 1'b0;
  endtask

  logic [63:0] timRd [5];
  logic        timTip [5];

  initial begin
    rst        = 1'b1;
    irqSrc     = '0;
    csrWen     = 1'b0;
    csrWaddr   = '0;
    csrWdata   = '0;
    csrRaddr   = '0;
    claim      = 1'b0;
    complete   = 1'b0;
    completeId = '0;
    #1;

    // ---- reset state ----
    applyReset();
    checkOutput("rst_rdata", csrRdata, 64'h0);
    checkOutput("rst_claim_id", 64'(claimId), 64'h0);
    checkOutput("rst_meip", 64'(meip), 64'h0);
    checkOutput("rst_mtip", 64'(mtip), 64'h0);
    csrRaddr = 12'h7C5;
    stepClock();
`ifdef INT_CTRL_TIMER_EN
    checkOutput("rst_mtimecmp", csrRdata, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    checkOutput("rst_mtimecmp", csrRdata, 64'h0);
`endif

    // ---- priority arbitration: ID1=2, ID3=5, threshold 1 ----
    applyReset();
    csrWrite(12'h7C2, 64'h142);
    csrWrite(12'h7C0, 64'h05);
    csrWrite(12'h7C1, 64'h1);
    csrRaddr = 12'h7C2;
    irqSrc = 8'h05;
    stepClock();
    checkOutput("prio_readback", csrRdata, 64'h142);
    checkOutput("meip_before", 64'(meip), 64'h0);
    stepClock();
    checkOutput("meip_raised", 64'(meip), 64'h1);
    pulseClaim();
    checkOutput("claim_id3", 64'(claimId), 64'h3);
    checkOutput("meip_at_claim", 64'(meip), 64'h1);
    irqSrc = 8'h00;
    csrRaddr = 12'h7C3;
    stepClock();
    checkOutput("meip_id1_left", 64'(meip), 64'h1);
    checkOutput("pending_id1", csrRdata, 64'h01);
    csrRaddr = 12'h7C4;
    stepClock();
    checkOutput("unmapped_read", csrRdata, 64'h0);

    // ---- equal priorities on ID2 and ID5 ----
    applyReset();
    csrWrite(12'h7C2, 64'h4020);
    csrWrite(12'h7C0, 64'h12);
    irqSrc = 8'h12;
    stepClock();
    stepClock();
    checkOutput("tie_meip", 64'(meip), 64'h1);
    pulseClaim();
    checkOutput("tie_claim_2", 64'(claimId), 64'h2);
    pulseClaim();
    checkOutput("tie_claim_5", 64'(claimId), 64'h5);
    pulseClaim();
    checkOutput("tie_claim_0", 64'(claimId), 64'h0);
    checkOutput("tie_meip_off", 64'(meip), 64'h0);

    // ---- complete handling on ID4 ----
    applyReset();
    csrWrite(12'h7C2, 64'h600);
    csrWrite(12'h7C0, 64'h08);
    irqSrc = 8'h08;
    stepClock();
    stepClock();
    pulseClaim();
    checkOutput("c4_claim", 64'(claimId), 64'h4);
    stepClock();
    checkOutput("c4_meip_low", 64'(meip), 64'h0);
    pulseComplete(4'd6);
    csrRaddr = 12'h7C3;
    stepClock();
    checkOutput("c6_no_pend", csrRdata, 64'h0);
    checkOutput("c6_meip_low", 64'(meip), 64'h0);
    pulseComplete(4'd4);
    stepClock();
    checkOutput("c4_idle_view", csrRdata, 64'h0);
    stepClock();
    checkOutput("c4_repend", csrRdata, 64'h08);
    stepClock();
    checkOutput("c4_meip_back", 64'(meip), 64'h1);
    checkOutput("c4_id_held", 64'(claimId), 64'h4);

    // ---- threshold gating and enable lowering ----
    applyReset();
    csrWrite(12'h7C2, 64'h5);
    csrWrite(12'h7C0, 64'h01);
    csrWrite(12'h7C1, 64'h5);
    irqSrc = 8'h01;
    stepClock();
    stepClock();
    stepClock();
    checkOutput("thr5_meip", 64'(meip), 64'h0);
    csrWrite(12'h7C1, 64'hFC);
    stepClock();
    checkOutput("thr4_meip", 64'(meip), 64'h1);
    csrRaddr = 12'h7C1;
    stepClock();
    checkOutput("thr_readback", csrRdata, 64'h4);
    csrWrite(12'h7C0, 64'h00);
    csrRaddr = 12'h7C3;
    stepClock();
    checkOutput("en0_meip", 64'(meip), 64'h0);
    stepClock();
    checkOutput("en0_still_pend", csrRdata, 64'h01);

    // ---- timer ----
    applyReset();
`ifdef INT_CTRL_TIMER_EN
    timRd[0] = 64'hFFFF_FFFF_FFFF_FFFE; timTip[0] = 1'b1;
    timRd[1] = 64'hFFFF_FFFF_FFFF_FFFF; timTip[1] = 1'b1;
    timRd[2] = 64'h0;                   timTip[2] = 1'b0;
    timRd[3] = 64'h1;                   timTip[3] = 1'b0;
    timRd[4] = 64'h2;                   timTip[4] = 1'b1;
    csrWrite(12'h7C5, 64'h2);
    csrRaddr = 12'h7C6;
    csrWrite(12'h7C6, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 5; i++) begin
      stepClock();
      checkOutput($sformatf("tim_mtime%0d", i), csrRdata, timRd[i]);
      checkOutput($sformatf("tim_mtip%0d", i), 64'(mtip), 64'(timTip[i]));
    end
`else
    timRd[0] = 64'h0;
    timTip[0] = 1'b0;
    csrWrite(12'h7C6, 64'h1234);
    csrWrite(12'h7C5, 64'h0);
    csrRaddr = 12'h7C6;
    stepClock();
    checkOutput("notim_mtime", csrRdata, timRd[0]);
    stepClock();
    checkOutput("notim_mtip", 64'(mtip), 64'(timTip[0]));
`endif

    // ---- reset with ID2 claimed and mtimecmp = 0 ----
    applyReset();
    csrWrite(12'h7C2, 64'h8);
    csrWrite(12'h7C0, 64'h02);
    irqSrc = 8'h02;
    stepClock();
    stepClock();
    pulseClaim();
    checkOutput("r2_claim", 64'(claimId), 64'h2);
    csrWrite(12'h7C5, 64'h0);
    stepClock();
`ifdef INT_CTRL_TIMER_EN
    checkOutput("r2_mtip_pre", 64'(mtip), 64'h1);
`else
    checkOutput("r2_mtip_pre", 64'(mtip), 64'h0);
`endif
    rst = 1'b1;
    csrRaddr = 12'h7C5;
    stepClock();
    checkOutput("r2_claim_id", 64'(claimId), 64'h0);
    checkOutput("r2_meip", 64'(meip), 64'h0);
    checkOutput("r2_mtip", 64'(mtip), 64'h0);
    rst = 1'b0;
    stepClock();
`ifdef INT_CTRL_TIMER_EN
    checkOutput("r2_mtimecmp", csrRdata, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    checkOutput("r2_mtimecmp", csrRdata, 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
